gameover_blitter: RTL
=====================

GAMEOVER_BLITTER -- requirements
Module: gameover_blitter

Interface
REQ-001 SHALL have parameter SCR_W, default 160, meaning screen width in pixels.
REQ-002 SHALL have parameter SCR_H, default 120, meaning screen height in pixels.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to draw a full screen.
REQ-006 SHALL have port rom_address  output  15  pixel address to the 9-bit, 160x120 image ROM.
REQ-007 SHALL have port rom_q  input  9  ROM data, valid in the cycle after rom_address is clocked.
REQ-008 SHALL have port x  output  8  VGA adapter column.
REQ-009 SHALL have port y  output  7  VGA adapter row.
REQ-010 SHALL have port colour  output  9  VGA adapter pixel colour.
REQ-011 SHALL have port plot  output  1  VGA adapter write strobe.
REQ-012 SHALL have port busy  output  1  high while a draw is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a draw completes.

Function
REQ-014 SHALL implement FSM states IDLE, PRIME, DRAW and FIN.
- IDLE -> PRIME when start=1.
- PRIME -> DRAW unconditionally.
- DRAW -> FIN after the last pixel is plotted.
- FIN -> IDLE unconditionally.
REQ-015 SHALL keep an address counter (15b), column counter xc (0..SCR_W-1) and row counter yc (0..SCR_H-1), all 0 in IDLE.
- rom_address is driven directly from the address counter.
- No multiplier: address increments by 1 whenever xc advances.
REQ-016 SHALL, in PRIME and in each DRAW cycle before the last fetch, increment the address counter and xc.
- xc wraps from SCR_W-1 to 0 and increments yc at the same edge.
- The fetch of address SCR_W*SCR_H-1 is the last; the counters then hold.
REQ-017 SHALL register x<=xc, y<=yc and plot<=1 on every PRIME or DRAW edge that issues a fetch, so that x/y lag rom_address by exactly one cycle.
REQ-018 SHALL drive colour combinationally from rom_q, matching the ROM's single-cycle read latency; x, y and plot are registered.
REQ-019 SHALL drive exactly SCR_W*SCR_H DRAW cycles with plot=1, in raster order (0,0),(1,0)..(159,0),(0,1)..(159,119).
REQ-020 SHALL hold plot=0 in IDLE, PRIME and FIN.
REQ-021 SHALL hold busy=1 in PRIME and DRAW, and busy=0 otherwise.
REQ-022 SHALL hold done=1 for exactly the single FIN cycle.
REQ-023 SHALL ignore start while busy=1 or in FIN; a start in the IDLE cycle immediately after FIN is accepted.
REQ-024 SHALL take 1 PRIME + 19200 DRAW + 1 FIN cycles from start acceptance to return to IDLE (defaults).
REQ-025 SHALL hold x, y and colour stable when plot=0; there is no x/y wrap beyond the last pixel.

Reset
REQ-026 SHALL, on reset=1 at any time including mid-DRAW, immediately force the following, with no partial-frame completion and no done pulse:
- state=IDLE;
- address counter, xc, yc, x, y = 0;
- plot=0, busy=0, done=0.
REQ-027 SHALL begin a new frame from (0,0) on the first start after reset deasserts.

Configuration
REQ-028 SHALL support macro GAMEOVER_BLITTER_TRANSPARENT_EN.
- When defined: in DRAW, plot is forced to 0 for any pixel whose rom_q equals 9'h000. Timing, counters and done behaviour are unchanged.
- When undefined: every pixel is plotted, including black.

Verification
REQ-029 SHALL cover: reset, then start pulse; ROM model returns address[8:0].
- First plot occurs 2 edges after start, with x=0, y=0, colour=0.
- Plot at x=159, y=0 carries colour=159.
- Plot at x=0, y=1 carries colour=160.
- Last plot is x=159, y=119, colour=19199 mod 512 = 255.
- Exactly 19200 plots, done high for 1 cycle, busy low after.
REQ-030 SHALL cover start re-asserted at DRAW cycle 500: no restart, plot count remains 19200, single done pulse.
REQ-031 SHALL cover reset asserted at DRAW cycle 8000:
- Asynchronously, before the next edge: plot=0, busy=0, rom_address=0.
- No done pulse.
- The next start redraws from (0,0) with 19200 plots.
REQ-032 SHALL cover start asserted in the IDLE cycle right after done: a second frame is accepted, busy goes high at the next edge, and 19200 further plots follow.
REQ-033 SHALL cover, with GAMEOVER_BLITTER_TRANSPARENT_EN defined, ROM model returning 0 for even addresses and 9'h1FF for odd addresses:
- Exactly 9600 plots, all colour=9'h1FF at odd x.
- done at the same cycle as the non-transparent build.

Source files
------------

// File: rtl/gameover_blitter.sv
// gameover_blitter: copies a full SCR_W x SCR_H image from a single-cycle-latency
// ROM to a VGA adapter in raster order, one pixel per clock.
// Optional build macro GAMEOVER_BLITTER_TRANSPARENT_EN: black (9'h000) pixels
// are not plotted; timing, counters and done behaviour are unchanged.
module gameover_blitter #(
  parameter int unsigned SCR_W = 160,
  parameter int unsigned SCR_H = 120
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [14:0] rom_address,
  input  logic [8:0]  rom_q,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [8:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam int unsigned AW        = 15;
  localparam int unsigned XW        = 8;
  localparam int unsigned YW        = 7;
  localparam int unsigned CW        = 9;
  localparam int unsigned LAST_ADDR = SCR_W * SCR_H - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    DRAW  = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [XW-1:0] xc_q, xc_d;
  logic [YW-1:0] yc_q, yc_d;
  logic          last_q, last_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          plot_q, plot_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] colour_q;
  logic          fetch;
  logic          plot_c;

  // State, counters and registered adapter outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      xc_q     <= '0;
      yc_q     <= '0;
      last_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      xc_q     <= xc_d;
      yc_q     <= yc_d;
      last_q   <= last_d;
      x_q      <= x_d;
      y_q      <= y_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      colour_q <= colour;
    end
  end

  // Next-state, fetch sequencing and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    xc_d    = xc_q;
    yc_d    = yc_q;
    last_d  = last_q;
    x_d     = x_q;
    y_d     = y_q;
    plot_d  = 1'b0;
    fetch   = 1'b0;

    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        xc_d   = '0;
        yc_d   = '0;
        last_d = 1'b0;
        if (start) state_d = PRIME;
      end
      PRIME: begin
        fetch   = 1'b1;
        state_d = DRAW;
      end
      DRAW: begin
        // Once the last address has been fetched, this cycle shows its pixel
        if (last_q) state_d = FIN;
        else        fetch   = 1'b1;
      end
      FIN: begin
        addr_d  = '0;
        xc_d    = '0;
        yc_d    = '0;
        last_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fetch latches the current column/row so x/y line up with rom_q next cycle
    if (fetch) begin
      x_d    = xc_q;
      y_d    = yc_q;
      plot_d = 1'b1;
      if (addr_q == AW'(LAST_ADDR)) begin
        last_d = 1'b1;
      end else begin
        addr_d = addr_q + AW'(1);
        if (xc_q == XW'(SCR_W - 1)) begin
          xc_d = '0;
          yc_d = yc_q + YW'(1);
        end else begin
          xc_d = xc_q + XW'(1);
        end
      end
    end

    busy_d = (state_d == PRIME) || (state_d == DRAW);
    done_d = (state_d == FIN);
  end

`ifdef GAMEOVER_BLITTER_TRANSPARENT_EN
  // Black pixels are skipped; the frame still takes the same number of cycles
  assign plot_c = plot_q && (rom_q != CW'(0));
`else
  assign plot_c = plot_q;
`endif

  assign rom_address = addr_q;
  assign x           = x_q;
  assign y           = y_q;
  assign plot        = plot_c;
  assign busy        = busy_q;
  assign done        = done_q;
  // ROM data passes straight through while plotting, otherwise the last value holds
  assign colour      = plot_c ? rom_q : colour_q;

endmodule
